if_prefetch_queue: RTL and testbench

- Instruction-fetch front end for the pipelined MIPS core. Replaces the single-cycle PC/ROM path with a variable-latency instruction-memory handshake and a small prefetch FIFO.
- Feeds the IF/ID register with {instr, pc4} pairs.
- Accepts PC redirects (taken branch from MEM, jump from ID) and stalls from ID.

---
 rtl/if_prefetch_queue_pkg.sv | 22 ++
 rtl/if_prefetch_queue_fifo.sv | 99 +++++++++
 rtl/if_prefetch_queue.sv | 150 +++++++++++++++
 tb/tb_if_prefetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_prefetch_queue_pkg;

    // Fetch sequencer: at most one instruction-memory request outstanding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no request on the bus
        ST_WAIT  = 2'd1,  // request live, response will be kept
        ST_DRAIN = 2'd2   // request live, response is stale and dropped
    } fetch_state_t;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    // One prefetch slot: instruction word plus the address of its successor
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Prefetch FIFO of {instr, pc4} entries with a registered, zero-when-empty head.
// Latency: a push is visible at the head one cycle later.
// Backpressure: full is exported; pushes while full are dropped, pops while empty are ignored.
module pf_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_dat,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count_nxt,
    output fetch_entry_t  head_dat
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_head_vld;
    fetch_entry_t  r_head_dat;
    fetch_entry_t  r_mem [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_remain;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] w_wr_nxt;
    logic [AW-1:0] w_rd_nxt;
    logic          w_head_vld_nxt;
    fetch_entry_t  w_head_nxt;

    assign w_pop    = pop & r_head_vld;
    assign w_push   = push & (r_count != DEPTH_C);
    assign w_remain = r_count - CW'(w_pop);

    // Pointer and occupancy update; flush wins over any push/pop this cycle
    always_comb begin
        w_wr_nxt  = r_wr_ptr + AW'(w_push);
        w_rd_nxt  = r_rd_ptr + AW'(w_pop);
        w_cnt_nxt = w_remain + CW'(w_push);
        if (flush) begin
            w_wr_nxt  = '0;
            w_rd_nxt  = '0;
            w_cnt_nxt = '0;
        end
    end

    // Next head: bypass the push data when it lands in an otherwise empty queue
    always_comb begin
        w_head_vld_nxt = (w_cnt_nxt != '0);
        w_head_nxt     = '0;
        if (w_head_vld_nxt) begin
            if (w_remain == '0) begin
                w_head_nxt = push_dat;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    // Control state and registered head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head_vld <= 1'b0;
            r_head_dat <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_cnt_nxt;
            r_head_vld <= w_head_vld_nxt;
            r_head_dat <= w_head_nxt;
        end
    end

    // Entry storage; contents are only meaningful below r_count, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    assign full      = (r_count == DEPTH_C);
    assign empty     = ~r_head_vld;
    assign count_nxt = w_cnt_nxt;
    assign head_dat  = r_head_dat;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: one-outstanding imem handshake feeding a prefetch FIFO to ID.
// Latency: imem ack to id_valid is 1 cycle; back-to-back acks sustain 1 instr/cycle.
// Backpressure: id_ready low fills the FIFO; new requests stop once the in-flight slot would not fit.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_imem_addr;
    logic         r_imem_req;

    logic [31:0]  w_redir_pc;
    logic [31:0]  w_addr_inc;
    logic         w_pop;
    logic         w_push;
    logic         w_room;
    logic         w_issue;
    logic [31:0]  w_issue_addr;
    logic [31:0]  w_fetch_pc_nxt;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [CW-1:0] w_count_nxt;
    fetch_entry_t w_push_dat;
    fetch_entry_t w_head_dat;

    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_addr_inc = r_imem_addr + PC_INC;
    assign w_pop      = ~w_fifo_empty & id_ready;
    assign w_push     = (r_state == ST_WAIT) & imem_ack & ~redirect & ~w_fifo_full;
    assign w_push_dat = {imem_rdata, w_addr_inc};
    // The next request always needs a free slot for its eventual response
    assign w_room     = (w_count_nxt < DEPTH_C);

    pf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_dat  (w_push_dat),
        .pop       (w_pop),
        .flush     (redirect),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count_nxt (w_count_nxt),
        .head_dat  (w_head_dat)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: redirect dominates; a redirect with no ack leaves a stale response to drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!redirect && w_room) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    w_state_nxt = imem_ack ? ST_IDLE : ST_DRAIN;
                end else if (imem_ack) begin
                    w_state_nxt = w_room ? ST_WAIT : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs of the sequencer: request issue, its address, and the next sequential PC
    always_comb begin
        w_issue        = 1'b0;
        w_issue_addr   = r_fetch_pc;
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect) begin
            w_fetch_pc_nxt = w_redir_pc;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_issue      = w_room;
                    w_issue_addr = r_fetch_pc;
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        w_fetch_pc_nxt = w_addr_inc;
                        w_issue        = w_room;
                        w_issue_addr   = w_addr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered request interface and fetch PC; imem_addr only moves on issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc  <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_imem_req  <= 1'b0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_imem_req <= (w_state_nxt != ST_IDLE);
            if (w_issue) begin
                r_imem_addr <= w_issue_addr;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign id_valid  = ~w_fifo_empty;
    assign id_instr  = w_head_dat.instr;
    assign id_pc4    = w_head_dat.pc4;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a scoreboard of expected {instr, pc4} deliveries.
// Latency: checks sampled 1 time unit after each rising edge; scoreboard runs on falling edges.
// Backpressure: id_ready and imem_ack are driven per step to exercise stalls and delayed memory.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        w_ack;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] sb [$];
    logic        stale = 1'b0;

    // ROM: word n holds the value n
    assign imem_rdata = imem_addr >> 2;
    assign w_rdata    = w_addr >> 2;

    always #5 clk = ~clk;

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata)
    );

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .id_ready    (1'b1),
        .id_valid    (w_valid),
        .id_instr    (w_instr),
        .id_pc4      (w_pc4),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expectations enter on accepted memory transfers, leave on ID pops
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                stale = 1'b0;
            end else begin
                if (id_valid && id_ready) begin
                    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) chk("pop_entry", {id_instr, id_pc4}, sb.pop_front());
                end
                if (redirect) sb.delete();
                if (imem_req && imem_ack) begin
                    if (!redirect && !stale) sb.push_back({imem_addr >> 2, imem_addr + 32'd4});
                    stale = 1'b0;
                end else if (imem_req && redirect) begin
                    stale = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_addr [4];
        logic [31:0] wrap_pc4 [4];
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        wrap_pc4  = '{32'h0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
        id_ready = 1'b0; imem_ack = 1'b0; w_ack = 1'b0;

        // Reset values
        cyc(); cyc();
        chk("rst_req",   imem_req,  0);
        chk("rst_addr",  imem_addr, 0);
        chk("rst_vld",   id_valid,  0);
        chk("rst_instr", id_instr,  0);
        chk("rst_pc4",   id_pc4,    0);
        chk("rst_waddr", w_addr,    64'hFFFF_FFF8);

        // Sequential fetch, ack always 1, ID always ready
        imem_ack = 1'b1; id_ready = 1'b1; reset = 1'b0;
        cyc();
        chk("seq_req0",  imem_req,  1);
        chk("seq_addr0", imem_addr, 0);
        chk("seq_vld0",  id_valid,  0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("seq_addr",  imem_addr, 64'(32'(4 * k)));
            chk("seq_vld",   id_valid,  1);
            chk("seq_instr", id_instr,  64'(32'(k - 1)));
            chk("seq_pc4",   id_pc4,    64'(32'(4 * k)));
        end

        // Backpressure: fill four entries, stop requesting, then drain in order
        reset = 1'b1; cyc(); cyc();
        imem_ack = 1'b1; id_ready = 1'b0; reset = 1'b0;
        repeat (5) cyc();
        chk("bp_req_off", imem_req, 0);
        chk("bp_fill",    64'(sb.size()), 4);
        repeat (2) cyc();
        chk("bp_req_hold", imem_req, 0);
        chk("bp_vld",      id_valid, 1);
        chk("bp_head",     id_instr, 0);
        id_ready = 1'b1;
        cyc();
        chk("bp_resume_req",  imem_req,  1);
        chk("bp_resume_addr", imem_addr, 32'h10);
        chk("bp_next_instr",  id_instr,  1);
        chk("bp_next_pc4",    id_pc4,    8);
        repeat (8) cyc();

        // Redirect while the 0x8 request waits for a delayed ack
        reset = 1'b1; cyc(); cyc();
        imem_ack = 1'b1; id_ready = 1'b1; reset = 1'b0;
        cyc(); cyc(); cyc();
        imem_ack = 1'b0;
        chk("rd_addr_pend", imem_addr, 8);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        redirect = 1'b0;
        chk("rd_drain_req",  imem_req,  1);
        chk("rd_drain_addr", imem_addr, 8);
        chk("rd_drain_vld",  id_valid,  0);
        cyc();
        chk("rd_hold_addr", imem_addr, 8);
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("rd_idle_req", imem_req, 0);
        chk("rd_idle_vld", id_valid, 0);
        cyc();
        chk("rd_new_req",  imem_req,  1);
        chk("rd_new_addr", imem_addr, 32'h40);
        chk("rd_new_vld",  id_valid,  0);
        imem_ack = 1'b1;
        cyc();
        chk("rd_data_vld",   id_valid, 1);
        chk("rd_data_instr", id_instr, 32'h10);
        chk("rd_data_pc4",   id_pc4,   32'h44);

        // Redirect, ack and pop together with two entries queued
        reset = 1'b1; cyc(); cyc();
        imem_ack = 1'b1; id_ready = 1'b0; reset = 1'b0;
        cyc(); cyc(); cyc();
        chk("sim_fill", 64'(sb.size()), 2);
        chk("sim_addr", imem_addr, 8);
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
        cyc();
        redirect = 1'b0;
        chk("sim_vld",   id_valid, 0);
        chk("sim_instr", id_instr, 0);
        chk("sim_req",   imem_req, 0);
        cyc();
        chk("sim_new_req",  imem_req,  1);
        chk("sim_new_addr", imem_addr, 32'h100);
        cyc();
        chk("sim_new_instr", id_instr, 32'h40);
        chk("sim_new_pc4",   id_pc4,   32'h104);

        // Reset asserted between edges with a request pending and a non-zero head
        reset = 1'b1; cyc(); cyc();
        imem_ack = 1'b1; id_ready = 1'b0; reset = 1'b0;
        cyc(); cyc(); cyc();
        imem_ack = 1'b0; id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        chk("mr_pre_instr", id_instr, 1);
        chk("mr_pre_req",   imem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_req",   imem_req,  0);
        chk("mr_vld",   id_valid,  0);
        chk("mr_instr", id_instr,  0);
        chk("mr_addr",  imem_addr, 0);
        imem_ack = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("mr_late_ack_vld", id_valid,  0);
        chk("mr_first_addr",   imem_addr, 0);
        chk("mr_first_req",    imem_req,  1);
        imem_ack = 1'b0;

        // PC wrap-around on the instance reset to 0xFFFFFFF8
        reset = 1'b1; cyc(); cyc();
        w_ack = 1'b1; reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("wrap_addr", w_addr, wrap_addr[k]);
            if (k == 0) chk("wrap_vld0", w_valid, 0);
            else        chk("wrap_pc4",  w_pc4,   wrap_pc4[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
